// File: rtl/mac_ctrl_arb_pkg.sv
// Shared types and defaults for the MAC control-port arbiter.
package mac_ctrl_pkg;

    // Arbiter sequencing: wait for a request, run it on the MAC, answer the owner.
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        RESP = 2'd2
    } state_t;

    // Latched operation of the granted requester.
    typedef enum logic {
        OP_RD = 1'b0,
        OP_WR = 1'b1
    } op_t;

    localparam int          DEF_ADDR_W   = 8;
    localparam int          DEF_DATA_W   = 32;
    localparam logic [31:0] DEF_ERR_DATA = 32'hDEADBEEF;

    // A write strobe wins over a simultaneous read strobe.
    function automatic op_t decode_op(input logic wr);
        return wr ? OP_WR : OP_RD;
    endfunction

endpackage

// File: rtl/mac_ctrl_arb_if.sv
// Bundle of both requester ports, the MAC control port and arbiter status.
interface mac_ctrl_arb_if
    import mac_ctrl_pkg::*;
#(
    parameter int ADDR_W = DEF_ADDR_W,
    parameter int DATA_W = DEF_DATA_W
);
    logic [ADDR_W-1:0] m0_address,     m1_address;
    logic              m0_read,        m1_read;
    logic              m0_write,       m1_write;
    logic [DATA_W-1:0] m0_writedata,   m1_writedata;
    logic [DATA_W-1:0] m0_readdata,    m1_readdata;
    logic              m0_waitrequest, m1_waitrequest;

    logic [ADDR_W-1:0] s_address;
    logic              s_read;
    logic              s_write;
    logic [DATA_W-1:0] s_writedata;
    logic [DATA_W-1:0] s_readdata;
    logic              s_waitrequest;

    logic [1:0]        grant;
    logic              err_timeout;

    // Arbiter side: serves the requesters, drives the MAC.
    modport slave (
        input  m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
        input  m0_writedata, m1_writedata,
        output m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
        output s_address, s_read, s_write, s_writedata,
        input  s_readdata, s_waitrequest,
        output grant, err_timeout
    );

    // Environment side: the requesters and the MAC control port.
    modport master (
        output m0_address, m1_address, m0_read, m1_read, m0_write, m1_write,
        output m0_writedata, m1_writedata,
        input  m0_readdata, m1_readdata, m0_waitrequest, m1_waitrequest,
        input  s_address, s_read, s_write, s_writedata,
        output s_readdata, s_waitrequest,
        input  grant, err_timeout
    );

endinterface

// File: rtl/mac_ctrl_arb_rr_arb2.sv
// Two-way round-robin grant: a lone requester always wins, a tie goes
// to whichever requester was not served last.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last_m0,
    output logic [1:0] gnt
);

    // One-hot grant from the request pair and the last-served pointer.
    always_comb begin
        gnt = req;
        if (req == 2'b11) begin
            gnt = last_m0 ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/mac_ctrl_arb.sv
// Shares one MAC Avalon-MM control port between the config sequencer (m0)
// and a host/status poller (m1): one transaction at a time, round-robin,
// with an abort when the MAC holds waitrequest too long.
module mac_ctrl_arb
    import mac_ctrl_pkg::*;
#(
    parameter int              ADDR_W   = DEF_ADDR_W,
    parameter int              DATA_W   = DEF_DATA_W,
    parameter int              TIMEOUT  = 1023,
    parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(DEF_ERR_DATA)
) (
    input  logic           clk,
    input  logic           rst_n,
    mac_ctrl_arb_if.slave  bus
);

    localparam int CNT_W = $clog2(TIMEOUT + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT);

    state_t            state_q, state_d;
    logic [1:0]        req;
    logic [1:0]        gnt_arb;
    logic [1:0]        grant_q;
    logic              last_m0_q;
    op_t               op_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [DATA_W-1:0] rdata0_q, rdata1_q;
    logic [CNT_W-1:0]  cnt_q;
    logic              err_q;
    logic              done;
    logic              abort;

    assign req = {bus.m1_read | bus.m1_write, bus.m0_read | bus.m0_write};

    rr_arb2 u_rr_arb2 (
        .req     (req),
        .last_m0 (last_m0_q),
        .gnt     (gnt_arb)
    );

    // Latched transaction drives the MAC; reads of the owner come from per-requester registers.
    assign bus.s_address   = addr_q;
    assign bus.s_writedata = wdata_q;
    assign bus.m0_readdata = rdata0_q;
    assign bus.m1_readdata = rdata1_q;
    assign bus.grant       = grant_q;

    // State register; reset drops any in-flight strobe immediately.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next state, completion/abort decode and the strobe/handshake outputs.
    always_comb begin
        state_d            = state_q;
        done               = 1'b0;
        abort              = 1'b0;
        bus.s_read         = 1'b0;
        bus.s_write        = 1'b0;
        bus.m0_waitrequest = 1'b1;
        bus.m1_waitrequest = 1'b1;
        bus.err_timeout    = 1'b0;
        case (state_q)
            IDLE: begin
                if (|req) begin
                    state_d = BUSY;
                end
            end
            BUSY: begin
                bus.s_read  = (op_q == OP_RD);
                bus.s_write = (op_q == OP_WR);
                if (!bus.s_waitrequest) begin
                    done    = 1'b1;
                    state_d = RESP;
                end else if (cnt_q == CNT_LAST) begin
                    // This stalled cycle brings the count to TIMEOUT.
                    abort   = 1'b1;
                    state_d = RESP;
                end
            end
            RESP: begin
                bus.m0_waitrequest = ~grant_q[0];
                bus.m1_waitrequest = ~grant_q[1];
                bus.err_timeout    = err_q;
                state_d            = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Ownership: granted in IDLE, released in RESP, which also moves the rr pointer.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            grant_q   <= 2'b00;
            last_m0_q <= 1'b0;
        end else if (state_q == IDLE && |req) begin
            grant_q <= gnt_arb;
        end else if (state_q == RESP) begin
            grant_q   <= 2'b00;
            last_m0_q <= grant_q[0];
        end
    end

    // Capture the winner's address, data and op so it may drop them mid-transaction.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            addr_q  <= '0;
            wdata_q <= '0;
            op_q    <= OP_RD;
        end else if (state_q == IDLE && |req) begin
            if (gnt_arb[1]) begin
                addr_q  <= bus.m1_address;
                wdata_q <= bus.m1_writedata;
                op_q    <= decode_op(bus.m1_write);
            end else begin
                addr_q  <= bus.m0_address;
                wdata_q <= bus.m0_writedata;
                op_q    <= decode_op(bus.m0_write);
            end
        end
    end

    // Stall counter: cleared per transaction, counts stalled BUSY cycles, saturates.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else if (state_q == IDLE) begin
            cnt_q <= '0;
        end else if (state_q == BUSY && bus.s_waitrequest && cnt_q != CNT_MAX) begin
            cnt_q <= cnt_q + 1'b1;
        end
    end

    // Owner's read data and timeout flag, presented during RESP.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata0_q <= '0;
            rdata1_q <= '0;
            err_q    <= 1'b0;
        end else if (state_q == IDLE) begin
            err_q <= 1'b0;
        end else if (state_q == BUSY) begin
            if (abort) begin
                err_q <= 1'b1;
                if (grant_q[1]) rdata1_q <= ERR_DATA;
                else            rdata0_q <= ERR_DATA;
            end else if (done && op_q == OP_RD) begin
                if (grant_q[1]) rdata1_q <= bus.s_readdata;
                else            rdata0_q <= bus.s_readdata;
            end
        end
    end

endmodule
